// File: rtl/lpm_reduce_pipe.sv
// Pipelined per-bit AND/OR/XOR/pass reduction of lpm_size operand words, with optional inversion.
// Latency is lpm_pipeline enabled edges (0 = combinational); no backpressure, and clken=0 freezes every stage.
module lpm_reduce_pipe #(
  parameter     lpm_type     = "lpm_reduce_pipe",
  parameter int lpm_width    = 1,
  parameter int lpm_size     = 2,
  parameter int lpm_pipeline = 1,
  parameter     lpm_hint     = "UNUSED"
) (
  input  logic                          clock,
  input  logic                          sclr,
  input  logic                          clken,
  input  logic                          data_valid,
  input  logic [2:0]                    op,
  input  logic [lpm_size*lpm_width-1:0] data,
  output logic [lpm_width-1:0]          result,
  output logic                          result_valid
);

  localparam int W  = lpm_width;
  localparam int DW = lpm_size * lpm_width;
  localparam     unused_info = {lpm_type, lpm_hint};

  // Fold operands lo..hi-1 into acc; operand 0 seeds acc, so pass (op=x11) leaves it untouched.
  function automatic logic [W-1:0] fold(
    input logic [W-1:0]  acc,
    input logic [DW-1:0] d,
    input logic [2:0]    o,
    input int            lo,
    input int            hi,
    input logic          last
  );
    logic [W-1:0] r;
    r = acc;
    for (int j = 1; j < lpm_size; j++) begin
      if (j >= lo && j < hi) begin
        case (o[1:0])
          2'b00:   r = r & d[j*W +: W];
          2'b01:   r = r | d[j*W +: W];
          2'b10:   r = r ^ d[j*W +: W];
          default: r = r;
        endcase
      end
    end
    if (last && o[2]) r = ~r;
    return r;
  endfunction

  if (lpm_pipeline == 0) begin : g_comb
    logic unused_ctl;
    assign unused_ctl   = clock ^ sclr ^ clken;
    assign result       = fold(data[W-1:0], data, op, 1, lpm_size, 1'b1);
    assign result_valid = data_valid;
  end else begin : g_pipe
    localparam int N = lpm_pipeline;

    logic [N-1:0][DW-1:0] dat_q, dat_v;
    logic [N-1:0][W-1:0]  acc_q, acc_v, acc_d;
    logic [N-1:0][2:0]    op_q, op_v;
    logic [N-1:0]         vld_q, vld_v;
    logic                 unused_bits;

    // Stage s folds its contiguous slice of operands 1..lpm_size-1; the last stage also inverts.
    always_comb begin
      dat_v = '0;
      acc_v = '0;
      op_v  = '0;
      vld_v = '0;
      acc_d = '0;
      dat_v[0] = data;
      acc_v[0] = data[W-1:0];
      op_v[0]  = op;
      vld_v[0] = data_valid;
      for (int s = 1; s < N; s++) begin
        dat_v[s] = dat_q[s-1];
        acc_v[s] = acc_q[s-1];
        op_v[s]  = op_q[s-1];
        vld_v[s] = vld_q[s-1];
      end
      for (int s = 0; s < N; s++) begin
        acc_d[s] = fold(acc_v[s], dat_v[s], op_v[s],
                        1 + ((lpm_size - 1) * s) / N,
                        1 + ((lpm_size - 1) * (s + 1)) / N,
                        s == N - 1);
      end
    end

    always_ff @(posedge clock) begin
      if (sclr) begin
        dat_q <= '0;
        acc_q <= '0;
        op_q  <= '0;
        vld_q <= '0;
      end else if (clken) begin
        dat_q <= dat_v;
        acc_q <= acc_d;
        op_q  <= op_v;
        vld_q <= vld_v;
      end
    end

    // Last-stage operand/op copies are never consumed; synthesis prunes them.
    assign unused_bits  = ^{dat_q, op_q};
    assign result       = acc_q[N-1];
    assign result_valid = vld_q[N-1];
  end

endmodule

// File: tb/tb_lpm_reduce_pipe.sv
// Bench for lpm_reduce_pipe: several configurations share one stimulus stream; a per-instance
// queue of expected words tagged with their due enabled-edge count is checked against each output.
module tb_lpm_reduce_pipe;

  localparam int NP = 4;
  localparam int PW [NP] = '{4, 17, 4, 1};
  localparam int PS [NP] = '{3, 8, 1, 8};
  localparam int PN [NP] = '{2, 3, 2, 1};
  localparam int CW [2]  = '{4, 4};
  localparam int CS [2]  = '{3, 1};

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] val;
  } exp_t;

  logic         clock;
  logic         sclr;
  logic         clken;
  logic         data_valid;
  logic [2:0]   op;
  logic [135:0] din;

  logic [3:0]  r_p0;
  logic [16:0] r_p1;
  logic [3:0]  r_p2;
  logic [0:0]  r_p3;
  logic [3:0]  r_c0;
  logic [3:0]  r_c1;
  logic        v_p0, v_p1, v_p2, v_p3, v_c0, v_c1;

  logic [31:0] p_res [NP];
  logic        p_vld [NP];
  logic [31:0] c_res [2];
  logic        c_vld [2];

  exp_t        sb [NP][$];
  logic        exp_v [NP];
  logic [31:0] exp_r [NP];
  int          n_chk = 0;
  int          n_bad = 0;
  int          en_cnt = 0;

  lpm_reduce_pipe #(.lpm_width(4), .lpm_size(3), .lpm_pipeline(2)) u_p0 (
    .clock(clock), .sclr(sclr), .clken(clken), .data_valid(data_valid), .op(op),
    .data(din[11:0]), .result(r_p0), .result_valid(v_p0));
  lpm_reduce_pipe #(.lpm_width(17), .lpm_size(8), .lpm_pipeline(3)) u_p1 (
    .clock(clock), .sclr(sclr), .clken(clken), .data_valid(data_valid), .op(op),
    .data(din[135:0]), .result(r_p1), .result_valid(v_p1));
  lpm_reduce_pipe #(.lpm_width(4), .lpm_size(1), .lpm_pipeline(2)) u_p2 (
    .clock(clock), .sclr(sclr), .clken(clken), .data_valid(data_valid), .op(op),
    .data(din[3:0]), .result(r_p2), .result_valid(v_p2));
  lpm_reduce_pipe #(.lpm_width(1), .lpm_size(8), .lpm_pipeline(1)) u_p3 (
    .clock(clock), .sclr(sclr), .clken(clken), .data_valid(data_valid), .op(op),
    .data(din[7:0]), .result(r_p3), .result_valid(v_p3));
  lpm_reduce_pipe #(.lpm_width(4), .lpm_size(3), .lpm_pipeline(0)) u_c0 (
    .clock(clock), .sclr(sclr), .clken(clken), .data_valid(data_valid), .op(op),
    .data(din[11:0]), .result(r_c0), .result_valid(v_c0));
  lpm_reduce_pipe #(.lpm_width(4), .lpm_size(1), .lpm_pipeline(0)) u_c1 (
    .clock(clock), .sclr(sclr), .clken(clken), .data_valid(data_valid), .op(op),
    .data(din[3:0]), .result(r_c1), .result_valid(v_c1));

  always_comb begin
    p_res[0] = 32'(r_p0);  p_vld[0] = v_p0;
    p_res[1] = 32'(r_p1);  p_vld[1] = v_p1;
    p_res[2] = 32'(r_p2);  p_vld[2] = v_p2;
    p_res[3] = 32'(r_p3);  p_vld[3] = v_p3;
    c_res[0] = 32'(r_c0);  c_vld[0] = v_c0;
    c_res[1] = 32'(r_c1);  c_vld[1] = v_c1;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: bit i of operand j sits at d[j*w+i].
  function automatic logic [31:0] ref_fn(input logic [135:0] d, input logic [2:0] o,
                                         input int w, input int s);
    logic [31:0] r;
    logic        b;
    r = '0;
    for (int i = 0; i < w; i++) begin
      b = d[i];
      if (o[1:0] != 2'b11) begin
        for (int j = 1; j < s; j++) begin
          case (o[1:0])
            2'b00:   b = b & d[j*w+i];
            2'b01:   b = b | d[j*w+i];
            default: b = b ^ d[j*w+i];
          endcase
        end
      end
      r[i] = b ^ o[2];
    end
    return r;
  endfunction

  task automatic drive(input logic s, input logic ce, input logic v,
                       input logic [2:0] o, input logic [135:0] d);
    sclr       = s;
    clken      = ce;
    data_valid = v;
    op         = o;
    din        = d;
  endtask

  // Check combinational instances, take one rising edge, then update and check the pipelined models.
  task automatic tick();
    exp_t e;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("c%0d_vld", k), 32'(c_vld[k]), 32'(data_valid));
      if (data_valid) chk($sformatf("c%0d_res", k), c_res[k], ref_fn(din, op, CW[k], CS[k]));
    end
    @(posedge clock);
    #1;
    if (!sclr && clken) en_cnt++;
    for (int k = 0; k < NP; k++) begin
      if (sclr) begin
        sb[k].delete();
        exp_v[k] = 1'b0;
        exp_r[k] = '0;
        chk($sformatf("p%0d_sclr_res", k), p_res[k], 32'd0);
        chk($sformatf("p%0d_sclr_vld", k), 32'(p_vld[k]), 32'd0);
      end else if (clken) begin
        if (data_valid) begin
          e.due = 32'(en_cnt + PN[k] - 1);
          e.val = ref_fn(din, op, PW[k], PS[k]);
          sb[k].push_back(e);
        end
        exp_v[k] = (sb[k].size() > 0) && (sb[k][0].due == 32'(en_cnt));
        if (exp_v[k]) begin
          e = sb[k].pop_front();
          exp_r[k] = e.val;
        end
        chk($sformatf("p%0d_vld", k), 32'(p_vld[k]), 32'(exp_v[k]));
        if (exp_v[k]) chk($sformatf("p%0d_res", k), p_res[k], exp_r[k]);
      end else begin
        chk($sformatf("p%0d_hold_vld", k), 32'(p_vld[k]), 32'(exp_v[k]));
        if (exp_v[k]) chk($sformatf("p%0d_hold_res", k), p_res[k], exp_r[k]);
      end
    end
  endtask

  initial begin
    logic [2:0]  ops  [5];
    logic [31:0] outs [5];
    logic [159:0] rnd;
    ops  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011};
    outs = '{32'h6, 32'hF, 32'h6, 32'h9, 32'h7};
    for (int k = 0; k < NP; k++) begin
      exp_v[k] = 1'b0;
      exp_r[k] = '0;
    end

    // Reset
    drive(1'b1, 1'b1, 1'b0, 3'b000, 136'h0);
    tick();
    tick();
    chk("rst_res", p_res[0], 32'h0);
    chk("rst_vld", 32'(p_vld[0]), 32'h0);

    // Every op on {F,E,7}, operand 0 = 7
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, ops[i], 136'hFE7);
      tick();
      drive(1'b0, 1'b1, 1'b0, 3'b000, 136'h0);
      tick();
      chk($sformatf("op%0d_res", i), p_res[0], outs[i]);
      chk($sformatf("op%0d_vld", i), 32'(p_vld[0]), 32'h1);
    end

    // Back-to-back words
    drive(1'b0, 1'b1, 1'b1, 3'b000, 136'hFE7);
    tick();
    drive(1'b0, 1'b1, 1'b1, 3'b001, 136'h124);
    tick();
    chk("b2b0_res", p_res[0], 32'h6);
    chk("b2b0_vld", 32'(p_vld[0]), 32'h1);
    drive(1'b0, 1'b1, 1'b1, 3'b010, 136'h333);
    tick();
    chk("b2b1_res", p_res[0], 32'h7);
    chk("b2b1_vld", 32'(p_vld[0]), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 136'h0);
    tick();
    chk("b2b2_res", p_res[0], 32'h3);
    chk("b2b2_vld", 32'(p_vld[0]), 32'h1);

    // Stall after the first edge
    drive(1'b0, 1'b1, 1'b1, 3'b000, 136'hFE7);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 136'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_vld", 32'(p_vld[0]), 32'h0);
    end
    drive(1'b0, 1'b1, 1'b0, 3'b000, 136'h0);
    tick();
    chk("stall_res", p_res[0], 32'h6);
    chk("stall_out_vld", 32'(p_vld[0]), 32'h1);

    // Clear mid-flight with clken low, and a word presented alongside sclr
    drive(1'b0, 1'b1, 1'b1, 3'b000, 136'hFE7);
    tick();
    drive(1'b0, 1'b1, 1'b1, 3'b001, 136'h124);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 136'h333);
    tick();
    chk("clr_res", p_res[0], 32'h0);
    chk("clr_vld", 32'(p_vld[0]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'b000, 136'h0);
      tick();
      chk("clr_drain_vld", 32'(p_vld[0]), 32'h0);
      chk("clr_drain_vld_w", 32'(p_vld[1]), 32'h0);
    end

    // Single operand XNOR: combinational ignores sclr, pipelined has latency 2
    drive(1'b1, 1'b1, 1'b1, 3'b110, 136'hA);
    #1;
    chk("deg_c1_res", c_res[1], 32'h5);
    chk("deg_c1_vld", 32'(c_vld[1]), 32'h1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 3'b110, 136'hA);
    tick();
    drive(1'b0, 1'b1, 1'b0, 3'b000, 136'h0);
    tick();
    chk("deg_p2_res", p_res[2], 32'h5);
    chk("deg_p2_vld", 32'(p_vld[2]), 32'h1);

    // Random stream
    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      drive($urandom_range(99) < 2, $urandom_range(99) < 80, $urandom_range(99) < 70,
            3'($urandom_range(7)), rnd[135:0]);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
